accumulator: RTL and testbench

- 8-bit accumulator register (ACC) for the 8-bit RISC CPU datapath.
- Captures the ALU/bus result on a clock edge when the control unit asserts ACCwrite, and holds it otherwise.
- The held value drives the ALU operand and memory-write paths continuously.
- Also provides combinational zero/negative status derived from the stored value, for branch decisions.

---
 rtl/accumulator_pkg.sv | 10 +
 rtl/accumulator.sv | 37 +++
 tb/tb_accumulator.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/accumulator_pkg.sv
`default_nettype none
// ============================================================================
// Module   : accumulator_pkg
// Brief    : Shared CPU datapath constants.
// Revision : 1.0 - initial release
// ============================================================================
package accumulator_pkg;
   localparam int DATA_W = 8;
endpackage
`default_nettype wire

// File: rtl/accumulator.sv
`default_nettype none
// ============================================================================
// Module   : accumulator
// Brief    : Load/hold accumulator register with zero/negative status flags.
// Revision : 1.0 - initial release
// ============================================================================
module accumulator
   import accumulator_pkg::*;
#(
   parameter int WIDTH = DATA_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ACCwrite,
   input  logic [WIDTH-1:0] in,
   output logic [WIDTH-1:0] out,
   output logic             zero,
   output logic             neg
);

   logic [WIDTH-1:0] r_acc;

   // Reset takes priority, so a write coinciding with reset is discarded.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_acc <= '0;
      end else if (ACCwrite) begin
         r_acc <= in;
      end
   end

   assign out  = r_acc;
   assign zero = (r_acc == '0);
   assign neg  = r_acc[WIDTH-1];

endmodule
`default_nettype wire

// File: tb/tb_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_accumulator
// Brief    : Self-checking bench for the accumulator register.
// Revision : 1.0 - initial release
// ============================================================================
module tb_accumulator;

   logic       clk;
   logic       rst_n;
   logic       ACCwrite;
   logic [7:0] in;
   logic [7:0] out;
   logic       zero;
   logic       neg;

   int n_cmp = 0;
   int n_err = 0;

   logic [7:0] exp_acc;
   logic       model_valid = 1'b0;

   accumulator dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .ACCwrite (ACCwrite),
      .in       (in),
      .out      (out),
      .zero     (zero),
      .neg      (neg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: the register value is whatever was last loaded at an edge, or 0 after reset.
   always @(posedge clk) begin
      if (rst_n === 1'b0) begin
         exp_acc     <= 8'h00;
         model_valid <= 1'b1;
      end else if (ACCwrite === 1'b1) begin
         exp_acc <= in;
      end
   end

   always @(negedge clk) begin
      if (model_valid) begin
         check("model_out",  out,         exp_acc);
         check("model_zero", {7'd0, zero}, {7'd0, exp_acc == 8'd0});
         check("model_neg",  {7'd0, neg},  {7'd0, exp_acc >= 8'h80});
      end
   end

   task automatic drive(input logic r, input logic w, input logic [7:0] d);
      rst_n    = r;
      ACCwrite = w;
      in       = d;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic expect_state(input string name, input logic [7:0] o, input logic z, input logic n);
      check({name, "_out"},  out,          o);
      check({name, "_zero"}, {7'd0, zero}, {7'd0, z});
      check({name, "_neg"},  {7'd0, neg},  {7'd0, n});
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      drive(1'b0, 1'b1, 8'hFF);
      tick();
      expect_state("reset", 8'h00, 1'b1, 1'b0);

      drive(1'b1, 1'b1, 8'h00);
      tick();
      expect_state("load_zero", 8'h00, 1'b1, 1'b0);

      // Data changes mid-cycle must not appear until the next edge.
      drive(1'b1, 1'b0, 8'h00);
      tick();
      #3;
      drive(1'b1, 1'b1, 8'hAA);
      #2;
      check("midcycle_hold", out, 8'h00);
      tick();
      expect_state("load_aa", 8'hAA, 1'b0, 1'b1);

      drive(1'b1, 1'b0, 8'h81);
      for (int i = 0; i < 4; i++) begin
         tick();
         in = 8'h81 ^ 8'(i);
         expect_state("hold", 8'hAA, 1'b0, 1'b1);
      end

      drive(1'b0, 1'b1, 8'h55);
      tick();
      expect_state("rst_beats_wr", 8'h00, 1'b1, 1'b0);
      drive(1'b1, 1'b1, 8'h55);
      tick();
      expect_state("load_55", 8'h55, 1'b0, 1'b0);

      // Back-to-back loads on consecutive edges.
      in = 8'h01;
      tick();
      expect_state("load_01", 8'h01, 1'b0, 1'b0);
      in = 8'h80;
      tick();
      expect_state("load_80", 8'h80, 1'b0, 1'b1);
      in = 8'h7F;
      tick();
      expect_state("load_7f", 8'h7F, 1'b0, 1'b0);

      // Reset pulse entirely between edges has no effect.
      drive(1'b1, 1'b0, 8'h00);
      tick();
      #2;
      rst_n = 1'b0;
      #3;
      check("async_mid", out, 8'h7F);
      rst_n = 1'b1;
      tick();
      expect_state("async_after", 8'h7F, 1'b0, 1'b0);

      drive(1'b1, 1'b1, 8'hFF);
      tick();
      expect_state("load_ff", 8'hFF, 1'b0, 1'b1);

      repeat (2) tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
